// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM state encoding for the SPI
// configuration register controller.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned IDX_W      = 3;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pad input, with a
// configurable reset (idle) level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Write-only SPI mode-0 slave that decodes 16-bit frames into writes of
// five configuration registers feeding the PWM/output driver.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       txn_err
);

  logic sclk_s2, copi_s2, ncs_s2;
  logic sclk_s3_q, ncs_s3_q;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s2));
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s2));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s2));

  logic sclk_rise, ncs_rise, ncs_fall;
  assign sclk_rise = sclk_s2 & ~sclk_s3_q;
  assign ncs_rise  = ncs_s2 & ~ncs_s3_q;
  assign ncs_fall  = ~ncs_s2 & ncs_s3_q;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]            shift_q, shift_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;
  frame_t                           frame;

  assign frame = frame_t'(shift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s3_q <= 1'b0;
      ncs_s3_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      regs_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_s3_q <= sclk_s2;
      ncs_s3_q  <= ncs_s2;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      regs_q    <= regs_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise && !ncs_s2) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s2};
          // Counter sticks one past a full frame so overruns stay detectable
          if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (ncs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if ((cnt_q == CNT_W'(FRAME_BITS)) && frame.wr && (frame.addr <= MAX_ADDR)) begin
          regs_d[IDX_W'(frame.addr)] = frame.data;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign en_reg_out_7_0  = regs_q[IDX_W'(ADDR_EN_OUT_LO)];
  assign en_reg_out_15_8 = regs_q[IDX_W'(ADDR_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = regs_q[IDX_W'(ADDR_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = regs_q[IDX_W'(ADDR_EN_PWM_HI)];
  assign pwm_duty_cycle  = regs_q[IDX_W'(ADDR_PWM_DUTY)];
  assign txn_done        = done_q;
  assign txn_err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed SPI frames push expected
// pulse/register snapshots; a monitor pops and compares on each pulse.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       txn_done, txn_err;

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        err;
    logic [39:0] regs;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] model [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] snap_model();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [39:0] snap_dut();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  // Monitor: every pulse must match the oldest expected frame outcome
  always @(negedge clk) begin
    if (rst_n && (txn_done || txn_err)) begin
      chk("done_err_exclusive", 40'(txn_done & txn_err), 40'(0));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%b err=%b expected no pulse", txn_done, txn_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("txn_done", 40'(txn_done), 40'(e.done));
        chk("txn_err", 40'(txn_err), 40'(e.err));
        chk("regs", snap_dut(), e.regs);
        chk("latency", 40'(cyc - e.cyc), 40'(4));
      end
    end
  end

  task automatic send_bits(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = v[i];
      repeat (3) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (3) @(posedge clk);
      #1 sclk = 1'b0;
    end
  endtask

  // Drive one frame; exp_ok is the hand-decided outcome of that frame
  task automatic frame(input logic [31:0] v, input int nbits, input logic exp_ok);
    exp_t e;
    @(posedge clk);
    #1 ncs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_bits(v, nbits);
    repeat (3) @(posedge clk);
    if (exp_ok) model[v[10:8]] = v[7:0];
    @(posedge clk);
    #1;
    e.done = exp_ok;
    e.err  = ~exp_ok;
    e.regs = snap_model();
    e.cyc  = cyc;
    sb.push_back(e);
    ncs = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("pulse_arrived", 40'(sb.size()), 40'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_regs", snap_dut(), 40'h0);
    chk("reset_done", 40'(txn_done), 40'(0));
    chk("reset_err", 40'(txn_err), 40'(0));
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    frame(32'h80F0, 16, 1'b1);
    frame(32'h8480, 16, 1'b1);
    frame(32'h84FF, 16, 1'b1);
    frame(32'h8400, 16, 1'b1);
    frame(32'h8555, 16, 1'b0);
    frame(32'h01AA, 16, 1'b0);
    frame(32'h823C >> 1, 15, 1'b0);
    frame({15'h0, 16'h823C, 1'b1}, 17, 1'b0);
    frame(32'h0, 0, 1'b0);
    frame(32'h823C, 16, 1'b1);
    frame(32'h83C3, 16, 1'b1);
    frame(32'h80AA, 16, 1'b1);
    frame(32'h8055, 16, 1'b1);
    drain();
    chk("final_out_lo", 40'(en_reg_out_7_0), 40'h55);
    chk("final_pwm_lo", 40'(en_reg_pwm_7_0), 40'h3C);
    chk("final_pwm_hi", 40'(en_reg_pwm_15_8), 40'hC3);
    chk("final_duty", 40'(pwm_duty_cycle), 40'h00);

    // Abort a frame with reset after 8 bits
    @(posedge clk);
    #1 ncs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_bits(32'h80, 8);
    rst_n = 1'b0;
    ncs   = 1'b1;
    copi  = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_out_lo", 40'(en_reg_out_7_0), 40'h0);
    chk("abort_out_hi", 40'(en_reg_out_15_8), 40'h0);
    chk("abort_pwm_lo", 40'(en_reg_pwm_7_0), 40'h0);
    chk("abort_pwm_hi", 40'(en_reg_pwm_15_8), 40'h0);
    chk("abort_duty", 40'(pwm_duty_cycle), 40'h0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    frame(32'h8011, 16, 1'b1);
    drain();
    #1;
    chk("post_reset_out_lo", 40'(en_reg_out_7_0), 40'h11);
    chk("post_reset_regs", snap_dut(), 40'h00_00_00_00_11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Configuration controller for the top-level PWM/output datapath.
- Receives write-only SPI (mode 0) frames from an external host on the dedicated inputs.
- Decodes each frame into address/data and commits it to one of five configuration registers: output enables, PWM enables, PWM duty.
- Sits between the pad inputs (ui_in) and the PWM/output driver block, which consumes its register outputs directly.

Parameters:
MAX_ADDR, 7'h04, highest valid register address; frames addressed above it are rejected.
FRAME_BITS, 16, exact bit count of a valid frame.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock from pad, asynchronous to clk.
copi  input  1  SPI data in from pad, asynchronous.
ncs  input  1  SPI chip select from pad, active low, asynchronous.
en_reg_out_7_0  output  8  output-enable bits for uo_out[7:0] (address 0x00).
en_reg_out_15_8  output  8  output-enable bits for uio_out[7:0] (address 0x01).
en_reg_pwm_7_0  output  8  PWM-mode select for uo_out[7:0] (address 0x02).
en_reg_pwm_15_8  output  8  PWM-mode select for uio_out[7:0] (address 0x03).
pwm_duty_cycle  output  8  shared PWM duty, 0x00=0%, 0xFF=100% (address 0x04).
txn_done  output  1  one-clk pulse: a frame was committed.
txn_err  output  1  one-clk pulse: a frame ended and was discarded.

Behaviour:
- Reset: clock is clk and reset is rst_n, asynchronous and active-low. While rst_n=0:
  - all five registers, txn_done and txn_err are 0;
  - bit counter and shift register are 0;
  - synchronizer flops are set to idle: sclk=0, ncs=1, copi=0.
- Synchronization:
  - sclk, copi and ncs each pass through a 2-flop synchronizer.
  - A third flop on sclk and on ncs provides edge detection.
  - sclk_rise = sclk_s2 & ~sclk_s3; ncs_rise = ncs_s2 & ~ncs_s3; ncs_fall = ~ncs_s2 & ncs_s3.
- Timing requirement on the host: sclk high ≥2 clk, sclk low ≥2 clk, ncs high between frames ≥3 clk.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on ncs_fall, clear counter and shift register, go to SHIFT.
  - SHIFT, on each sclk_rise while ncs_s2=0:
    - shift copi_s2 in MSB-first;
    - counter increments and saturates at FRAME_BITS+1, which marks an overrun.
  - SHIFT, on ncs_rise: go to COMMIT.
  - COMMIT lasts exactly one cycle, then returns to IDLE.
- Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit rule, evaluated in COMMIT:
  - Write condition: counter == FRAME_BITS, bit15 = 1 and address ≤ MAX_ADDR.
  - If the condition holds, write the addressed register and pulse txn_done.
  - Otherwise, registers are unchanged and txn_err pulses.
  - Error cases: short frame, overrun frame, read frame (bit15=0), address > MAX_ADDR.
- Latency:
  - The register value and txn_done appear on the 4th clk rising edge after ncs goes high: sync1, sync2, sync3/detect, commit.
  - The register value holds until the next valid write or reset.
- Boundary conditions:
  - sclk edges while ncs is high are ignored.
  - ncs_fall during COMMIT is impossible given the host timing; if it occurs, it is ignored and the frame is lost.
  - Reset asserted mid-frame discards the frame and clears all registers; no pulse is generated.
  - The same address written twice: last write wins.
  - Frame with 0 bits (ncs low then high) → txn_err.
- Only one txn_done or txn_err pulse per frame; never both.

Decomposition:
- Package spi_reg_pkg holds:
  - address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_PWM_DUTY=0x04;
  - FSM state enum (IDLE/SHIFT/COMMIT);
  - FRAME_BITS.
- Sub-module sync_2ff: parameter RESET_VAL, async active-low reset. Instantiated three times, with RESET_VAL 0 for sclk/copi and 1 for ncs.

Test Plan:
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) → en_reg_out_7_0=0xF0 on the 4th clk after ncs rises; txn_done pulses 1 cycle; other registers stay 0.
- Write frame 0x8480 → pwm_duty_cycle=0x80; then write 0x84FF → 0xFF; then write 0x8400 → 0x00; txn_done pulses once per frame.
- Frame 0x8555 (addr 0x05) → no register changes; txn_err pulses once; txn_done stays 0.
- Frame 0x01AA (read, addr 0x01) → en_reg_out_15_8 stays 0x00; txn_err pulses.
- 15-bit frame and 17-bit frame, each carrying 0x82 0x3C → en_reg_pwm_7_0 stays 0x00; txn_err pulses each time; a following good 0x823C frame sets 0x3C.
- After writing 0x83C3, start a new frame, assert rst_n=0 after 8 bits, release, then send a good 0x8011 frame → all registers read 0 after reset; no pulse for the aborted frame; en_reg_out_7_0=0x11 after the good frame.
